// File: rtl/ama_riscv_decode_queue_if.sv
// Shared decode types plus the fetch-side / issue-side handshake bundle of the decode queue.
// Latency: n/a (types and wiring only).
// Backpressure: in_valid/in_ready on the fetch side, out_valid/out_ready on the issue side.
//
// Port summary (slave = the queue):
//   fetch side : in_valid, in_ready, in_inst, in_pc, flush
//   issue side : out_valid, out_ready, out_inst, out_pc, out_decoded, out_fe_ctrl, out_illegal
//   status     : count (occupancy, $clog2(DEPTH+1) bits)

package ama_riscv_pkg;

    typedef logic [31:0] arch_width_t;

    localparam logic [6:0] OPC7_R_TYPE = 7'b011_0011;
    localparam logic [6:0] OPC7_I_TYPE = 7'b001_0011;
    localparam logic [6:0] OPC7_LOAD   = 7'b000_0011;
    localparam logic [6:0] OPC7_STORE  = 7'b010_0011;
    localparam logic [6:0] OPC7_BRANCH = 7'b110_0011;
    localparam logic [6:0] OPC7_JALR   = 7'b110_0111;
    localparam logic [6:0] OPC7_JAL    = 7'b110_1111;
    localparam logic [6:0] OPC7_LUI    = 7'b011_0111;
    localparam logic [6:0] OPC7_AUIPC  = 7'b001_0111;
    localparam logic [6:0] OPC7_SYSTEM = 7'b111_0011;
    localparam logic [6:0] OPC7_CUSTOM = 7'b000_1011;

    // ALU op encoding is {inst[30], fn3} for the arithmetic cases.
    typedef enum logic [3:0] {
        ALU_OP_ADD    = 4'b0000,
        ALU_OP_SLL    = 4'b0001,
        ALU_OP_SLT    = 4'b0010,
        ALU_OP_SLTU   = 4'b0011,
        ALU_OP_XOR    = 4'b0100,
        ALU_OP_SRL    = 4'b0101,
        ALU_OP_OR     = 4'b0110,
        ALU_OP_AND    = 4'b0111,
        ALU_OP_SUB    = 4'b1000,
        ALU_OP_SRA    = 4'b1101,
        ALU_OP_PASS_B = 4'b1111
    } alu_op_t;

    typedef enum logic {
        ALU_A_SEL_RS1 = 1'b0,
        ALU_A_SEL_PC  = 1'b1
    } alu_a_sel_t;

    typedef enum logic {
        ALU_B_SEL_RS2 = 1'b0,
        ALU_B_SEL_IMM = 1'b1
    } alu_b_sel_t;

    typedef enum logic [2:0] {
        IG_DISABLED = 3'd0,
        IG_I_TYPE   = 3'd1,
        IG_S_TYPE   = 3'd2,
        IG_B_TYPE   = 3'd3,
        IG_J_TYPE   = 3'd4,
        IG_U_TYPE   = 3'd5
    } ig_sel_t;

    typedef enum logic [1:0] {
        WB_SEL_DMEM = 2'd0,
        WB_SEL_ALU  = 2'd1,
        WB_SEL_INC4 = 2'd2,
        WB_SEL_CSR  = 2'd3
    } wb_sel_t;

    typedef enum logic [1:0] {
        PC_SEL_INC4       = 2'd0,
        PC_SEL_ALU        = 2'd1,
        PC_SEL_START_ADDR = 2'd3
    } pc_sel_t;

    typedef struct packed {
        logic mult;
        logic custom;
        logic csr;
        logic branch;
        logic jump;
        logic load;
        logic store;
    } itype_t;

    typedef struct packed {
        itype_t     itype;
        alu_op_t    alu_op;
        alu_a_sel_t alu_a_sel;
        alu_b_sel_t alu_b_sel;
        ig_sel_t    ig_sel;
        wb_sel_t    wb_sel;
        logic       rd_we;
        logic       dmem_en;
    } decoder_t;

    typedef struct packed {
        pc_sel_t pc_sel;
        logic    pc_we;
        logic    stall_if;
    } fe_ctrl_t;

    localparam decoder_t DECODER_RST_VAL = '0;
    localparam fe_ctrl_t FE_CTRL_RST_VAL = '{pc_sel: PC_SEL_START_ADDR, pc_we: 1'b0, stall_if: 1'b0};

endpackage

interface ama_riscv_decode_queue_if #(
    parameter int DEPTH = 4
);
    import ama_riscv_pkg::*;

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic        in_valid;
    logic        in_ready;
    arch_width_t in_inst;
    arch_width_t in_pc;
    logic        flush;

    logic        out_valid;
    logic        out_ready;
    arch_width_t out_inst;
    arch_width_t out_pc;
    decoder_t    out_decoded;
    fe_ctrl_t    out_fe_ctrl;
    logic        out_illegal;

    logic [CNT_W-1:0] count;

    // Driven by fetch + issue (testbench / neighbouring stages).
    modport master (
        output in_valid, in_inst, in_pc, flush, out_ready,
        input  in_ready, out_valid, out_inst, out_pc, out_decoded, out_fe_ctrl, out_illegal, count
    );

    // The decode queue itself.
    modport slave (
        input  in_valid, in_inst, in_pc, flush, out_ready,
        output in_ready, out_valid, out_inst, out_pc, out_decoded, out_fe_ctrl, out_illegal, count
    );

endinterface

// File: rtl/ama_riscv_decode_queue.sv
// Buffered decode stage: DEPTH-entry FIFO of {inst, pc}, head entry decoded combinationally.
// Latency: 1 cycle from push edge to head visibility; decode adds no cycles (no bypass).
// Backpressure: in_ready = not full (registered only, ignores out_ready); out_valid = not empty.
//
// Ports:
//   clk, rst : clock, asynchronous active-high reset (pointers/count only, data not reset)
//   q        : ama_riscv_decode_queue_if.slave (fetch push side, issue pop side, flush, count)

module ama_riscv_decode_queue
    import ama_riscv_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter bit EN_MULT   = 1'b1,
    parameter bit EN_CUSTOM = 1'b1
)(
    input  logic                       clk,
    input  logic                       rst,
    ama_riscv_decode_queue_if.slave    q
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    // ------------------------------------------------------------------
    // FIFO control
    // ------------------------------------------------------------------
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    arch_width_t inst_mem_q [DEPTH];
    arch_width_t inst_mem_d [DEPTH];
    arch_width_t pc_mem_q   [DEPTH];
    arch_width_t pc_mem_d   [DEPTH];

    logic in_ready;
    logic out_valid;
    logic push;
    logic pop;

    assign in_ready  = (count_q != CNT_FULL);
    assign out_valid = (count_q != '0);

    // Flush wins over both handshakes in the same cycle.
    assign push = q.in_valid & in_ready & ~q.flush;
    assign pop  = out_valid & q.out_ready & ~q.flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (q.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_comb begin
        inst_mem_d = inst_mem_q;
        pc_mem_d   = pc_mem_q;
        if (push) begin
            inst_mem_d[wr_ptr_q] = q.in_inst;
            pc_mem_d[wr_ptr_q]   = q.in_pc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        inst_mem_q <= inst_mem_d;
        pc_mem_q   <= pc_mem_d;
    end

    // ------------------------------------------------------------------
    // Head decode
    // ------------------------------------------------------------------
    arch_width_t head_inst;
    arch_width_t head_pc;
    logic [6:0]  opc7;
    logic [2:0]  fn3;
    logic [6:0]  fn7;
    logic        rd_nz;

    assign head_inst = inst_mem_q[rd_ptr_q];
    assign head_pc   = pc_mem_q[rd_ptr_q];
    assign opc7      = head_inst[6:0];
    assign fn3       = head_inst[14:12];
    assign fn7       = head_inst[31:25];
    assign rd_nz     = (head_inst[11:7] != 5'd0);

    decoder_t dec;
    fe_ctrl_t fe;
    logic     legal;
    logic     rd_wr;

    always_comb begin
        dec   = DECODER_RST_VAL;
        fe    = '{pc_sel: PC_SEL_INC4, pc_we: 1'b1, stall_if: 1'b0};
        legal = (head_inst[1:0] == 2'b11);
        rd_wr = 1'b0;

        case (opc7)
            OPC7_R_TYPE: begin
                dec.alu_a_sel = ALU_A_SEL_RS1;
                dec.alu_b_sel = ALU_B_SEL_RS2;
                dec.ig_sel    = IG_DISABLED;
                dec.wb_sel    = WB_SEL_ALU;
                rd_wr         = 1'b1;
                if (fn7 == 7'h00) begin
                    dec.alu_op = alu_op_t'({1'b0, fn3});
                end else if (fn7 == 7'h20) begin
                    // Only SUB and SRA have an alternate encoding.
                    dec.alu_op = alu_op_t'({1'b1, fn3});
                    if (!(fn3 == 3'b000 || fn3 == 3'b101)) legal = 1'b0;
                end else if (fn7 == 7'h01) begin
                    // Multiplier consumes fn3 directly; ALU op is don't-care.
                    dec.itype.mult = 1'b1;
                    dec.alu_op     = ALU_OP_ADD;
                    if (!EN_MULT) legal = 1'b0;
                end else begin
                    legal = 1'b0;
                end
            end

            OPC7_I_TYPE: begin
                dec.alu_a_sel = ALU_A_SEL_RS1;
                dec.alu_b_sel = ALU_B_SEL_IMM;
                dec.ig_sel    = IG_I_TYPE;
                dec.wb_sel    = WB_SEL_ALU;
                rd_wr         = 1'b1;
                // inst[30] only selects SRAI; elsewhere it is immediate data.
                dec.alu_op    = alu_op_t'({(fn3 == 3'b101) & head_inst[30], fn3});
                if (fn3[1:0] == 2'b01) begin
                    if (!((fn7 == 7'h00) || (fn7 == 7'h20 && fn3 == 3'b101))) legal = 1'b0;
                end
            end

            OPC7_LOAD: begin
                dec.alu_b_sel    = ALU_B_SEL_IMM;
                dec.ig_sel       = IG_I_TYPE;
                dec.wb_sel       = WB_SEL_DMEM;
                dec.dmem_en      = 1'b1;
                dec.itype.load   = 1'b1;
                rd_wr            = 1'b1;
                if (fn3 == 3'b011 || fn3 == 3'b110 || fn3 == 3'b111) legal = 1'b0;
            end

            OPC7_STORE: begin
                dec.alu_b_sel   = ALU_B_SEL_IMM;
                dec.ig_sel      = IG_S_TYPE;
                dec.dmem_en     = 1'b1;
                dec.itype.store = 1'b1;
                if (fn3 > 3'b010) legal = 1'b0;
            end

            OPC7_BRANCH: begin
                // Predicted not taken: fetch keeps going sequentially.
                dec.alu_a_sel    = ALU_A_SEL_PC;
                dec.alu_b_sel    = ALU_B_SEL_IMM;
                dec.ig_sel       = IG_B_TYPE;
                dec.itype.branch = 1'b1;
                if (fn3 == 3'b010 || fn3 == 3'b011) legal = 1'b0;
            end

            OPC7_JALR: begin
                dec.alu_a_sel  = ALU_A_SEL_RS1;
                dec.alu_b_sel  = ALU_B_SEL_IMM;
                dec.ig_sel     = IG_I_TYPE;
                dec.wb_sel     = WB_SEL_INC4;
                dec.itype.jump = 1'b1;
                rd_wr          = 1'b1;
                fe.pc_sel      = PC_SEL_ALU;
                fe.stall_if    = 1'b1;
                if (fn3 != 3'b000) legal = 1'b0;
            end

            OPC7_JAL: begin
                dec.alu_a_sel  = ALU_A_SEL_PC;
                dec.alu_b_sel  = ALU_B_SEL_IMM;
                dec.ig_sel     = IG_J_TYPE;
                dec.wb_sel     = WB_SEL_INC4;
                dec.itype.jump = 1'b1;
                rd_wr          = 1'b1;
                fe.pc_sel      = PC_SEL_ALU;
                fe.stall_if    = 1'b1;
            end

            OPC7_LUI: begin
                dec.alu_b_sel = ALU_B_SEL_IMM;
                dec.ig_sel    = IG_U_TYPE;
                dec.wb_sel    = WB_SEL_ALU;
                dec.alu_op    = ALU_OP_PASS_B;
                rd_wr         = 1'b1;
            end

            OPC7_AUIPC: begin
                dec.alu_a_sel = ALU_A_SEL_PC;
                dec.alu_b_sel = ALU_B_SEL_IMM;
                dec.ig_sel    = IG_U_TYPE;
                dec.wb_sel    = WB_SEL_ALU;
                rd_wr         = 1'b1;
            end

            OPC7_SYSTEM: begin
                dec.alu_b_sel = ALU_B_SEL_IMM;
                dec.ig_sel    = IG_I_TYPE;
                dec.wb_sel    = WB_SEL_CSR;
                dec.itype.csr = 1'b1;
                rd_wr         = 1'b1;
            end

            OPC7_CUSTOM: begin
                dec.alu_a_sel    = ALU_A_SEL_RS1;
                dec.alu_b_sel    = ALU_B_SEL_RS2;
                dec.wb_sel       = WB_SEL_ALU;
                dec.itype.custom = 1'b1;
                rd_wr            = 1'b1;
                if (!EN_CUSTOM) legal = 1'b0;
            end

            default: legal = 1'b0;
        endcase

        dec.rd_we = rd_wr & rd_nz;

        // Illegal or empty head presents clean reset bundles downstream.
        if (!legal || !out_valid) begin
            dec = DECODER_RST_VAL;
            fe  = FE_CTRL_RST_VAL;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign q.in_ready    = in_ready;
    assign q.out_valid   = out_valid;
    assign q.out_inst    = head_inst;
    assign q.out_pc      = head_pc;
    assign q.out_decoded = dec;
    assign q.out_fe_ctrl = fe;
    assign q.out_illegal = out_valid & ~legal;
    assign q.count       = count_q;

endmodule

// File: doc/ama_riscv_decode_queue.md
# ama_riscv_decode_queue

Parametrised decode stage with buffering. It sits between fetch and the issue/execute stage. Incoming instruction/PC pairs are held in a DEPTH-entry FIFO, and the head entry is decoded into the standard `decoder_t` / `fe_ctrl_t` bundles. Unlike a bare combinational decoder, it adds valid/ready handshakes, flush, illegal-instruction detection, and build-time enables for the M and custom extensions.

## Interface
Parameters:
- DEPTH, 4, FIFO entries; power of two, >= 2
- EN_MULT, 1, decode RV32M (fn7 = 7'h01 on R-type) as legal; 0 makes it illegal
- EN_CUSTOM, 1, decode OPC7_CUSTOM as legal; 0 makes it illegal

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  fetch presents in_inst/in_pc
- in_ready  out  1  queue accepts an entry this cycle
- in_inst  in  arch_width_t  instruction word
- in_pc  in  arch_width_t  instruction PC
- flush  in  1  synchronous discard of all queued entries
- out_valid  out  1  head entry available
- out_ready  in  1  consumer takes the head this cycle
- out_inst  out  arch_width_t  head instruction
- out_pc  out  arch_width_t  head PC
- out_decoded  out  decoder_t  decode of the head
- out_fe_ctrl  out  fe_ctrl_t  frontend control for the head
- out_illegal  out  1  head is an illegal or disabled encoding
- count  out  $clog2(DEPTH+1)  current occupancy

## Operation
- Storage is a circular FIFO with registered wr_ptr, rd_ptr ($clog2(DEPTH) bits, natural wrap) and registered count.
- Push = in_valid & in_ready. Pop = out_valid & out_ready.
- in_ready = (count != DEPTH). It depends only on registered state, never on out_ready.
  - When full, a simultaneous pop does not enable a push that cycle.
- out_valid = (count != 0). out_inst/out_pc come straight from the head entry (rd_ptr).
- Push and pop in the same cycle: count is unchanged and both pointers advance.
- Decode is combinational from the head entry and uses the codebase decode table for R, I, LOAD, STORE, BRANCH, JALR, JAL, LUI, AUIPC, CUSTOM and SYSTEM.
  - Field extraction and `decoder_t`/`fe_ctrl_t` encodings are unchanged from the current core.
  - rd_we is gated by rd != x0.
- out_illegal = 1, with out_decoded = DECODER_RST_VAL and out_fe_ctrl = FE_CTRL_RST_VAL, when any of the following holds:
  - inst[1:0] != 2'b11
  - opcode is not one of the listed opcodes
  - R-type with fn7 not in {7'h00, 7'h20, 7'h01}
  - R-type with fn7 = 7'h20 and fn3 not in {3'b000, 3'b101}
  - fn7 = 7'h01 with EN_MULT = 0
  - OPC7_CUSTOM with EN_CUSTOM = 0
  - I-type shift (fn3[1:0] = 01) with inst[31:25] not in {7'h00, 7'h20}, or 7'h20 with fn3 = 001
  - LOAD fn3 in {011, 110, 111}, STORE fn3 > 010, BRANCH fn3 in {010, 011}, JALR fn3 != 000
- Illegal entries are still delivered and popped normally; the consumer raises the exception.
- When out_valid = 0: out_illegal = 0, out_decoded = DECODER_RST_VAL, out_fe_ctrl = FE_CTRL_RST_VAL.
- flush:
  - Next edge: wr_ptr = rd_ptr = 0, count = 0.
  - Any push and pop in the flush cycle are discarded; flush has priority.
- Reset: wr_ptr = rd_ptr = 0, count = 0, so out_valid = 0 and in_ready = 1. FIFO data is not reset.

## Timing
- Latency: an entry pushed at edge N is visible on out_* in the cycle after edge N. There is no same-cycle bypass.
- Throughput: one push and one pop per cycle in steady state.
- in_ready and out_valid are functions of registers only.
- out_decoded, out_fe_ctrl and out_illegal are combinational from registered head data; the path is one decode depth.
- flush asserted in cycle N: out_valid = 0 and in_ready = 1 in cycle N+1.
- rst asserted mid-operation: all outputs go to reset values immediately (asynchronous). Operation resumes on the first edge after deassertion.
- Pointer wrap from DEPTH-1 to 0 is seamless; ordering is preserved across the wrap.

## Test plan
- Reset, then push 0x00500093 (addi x1,x0,5) at pc 0x0 -> next cycle: out_valid = 1, out_illegal = 0, alu_b_sel = ALU_B_SEL_IMM, ig_sel = IG_I_TYPE, rd_we = 1, fe_ctrl.pc_sel = PC_SEL_INC4; count = 1.
- Push 0x002081B3 (add) and 0x022081B3 (mul) with out_ready = 0 -> count = 2. Pop both:
  - add: itype.mult = 0, alu_op = ALU_OP_ADD
  - mul: itype.mult = 1 with EN_MULT = 1; with EN_MULT = 0, out_illegal = 1 and decoded = DECODER_RST_VAL
- Push DEPTH entries with out_ready = 0 -> in_ready = 0 and count = DEPTH. Assert in_valid and out_ready together while full -> only the pop occurs, count = DEPTH-1, and the next cycle accepts a push.
- Stream 3*DEPTH entries with random out_ready and in_valid -> out_pc order matches push order across pointer wraps, with no loss or duplication.
- Push 0x00000000 and 0x4000F0B3 (fn7 = 0x20, fn3 = 111) -> both out_illegal = 1 with fe_ctrl = FE_CTRL_RST_VAL.
- With count = 3, assert flush plus in_valid -> next cycle count = 0 and out_valid = 0. Assert rst mid-stream -> outputs reset immediately, in_ready = 1 after deassertion.
